candy_stage_ctrl: RTL and testbench

Parametrised multi-cycle stage sequencer for the candy core: replaces a fixed four-state IF/ID/LOAD/WB rotation with an N-stage controller. Each stage is held until the stage reports completion through a done handshake. Stages can be skipped per instruction, and the controller supports start, halt at the instruction boundary, a retired-instruction counter and an optional stall watchdog. It sits in the core top level and drives the per-stage enables and `pc_enable`.

---
 rtl/candy_stage_ctrl.sv | 132 +++++++++++++
 tb/tb_candy_stage_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/candy_stage_ctrl.sv
// N-stage sequencer: holds each stage until its done bit, skips masked stages, counts retires.
// One cycle per stage minimum, stalls on done=0; optional stall watchdog under CANDY_STAGE_WDT_EN.
module candy_stage_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 255,
    localparam int SW        = $clog2(NUM_STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  halt,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic [NUM_STAGES-1:0] stage_skip,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [SW-1:0]         cur_stage,
    output logic                  pc_enable,
    output logic                  busy,
    output logic [CNT_W-1:0]      retired,
    output logic                  err
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERR    = 2'd2
    } state_t;

    state_t        state;
    logic          halt_seen;
    logic          nxt_found;
    logic [SW-1:0] nxt_idx;

`ifdef CANDY_STAGE_WDT_EN
    localparam int WDT_W = $clog2(TIMEOUT + 1);
    logic [WDT_W-1:0] wait_cnt;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [SW-1:0] idx);
        return {{(NUM_STAGES-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Lowest non-skipped stage above the current one; none found means the instruction retires.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (!nxt_found && (j > int'(cur_stage)) && !stage_skip[j]) begin
                nxt_found = 1'b1;
                nxt_idx   = SW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_stage <= '0;
            stage_en  <= '0;
            pc_enable <= 1'b0;
            busy      <= 1'b0;
            retired   <= '0;
            halt_seen <= 1'b0;
`ifdef CANDY_STAGE_WDT_EN
            wait_cnt  <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            pc_enable <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run && !halt) begin
                        state     <= S_ACTIVE;
                        cur_stage <= '0;
                        stage_en  <= stage_onehot('0);
                        busy      <= 1'b1;
                        halt_seen <= 1'b0;
`ifdef CANDY_STAGE_WDT_EN
                        wait_cnt  <= '0;
`endif
                    end
                end
                S_ACTIVE: begin
                    if (halt)
                        halt_seen <= 1'b1;
                    if (stage_done[cur_stage]) begin
`ifdef CANDY_STAGE_WDT_EN
                        wait_cnt <= '0;
`endif
                        if (nxt_found) begin
                            cur_stage <= nxt_idx;
                            stage_en  <= stage_onehot(nxt_idx);
                        end else begin
                            retired   <= retired + 1'b1;
                            pc_enable <= 1'b1;
                            halt_seen <= 1'b0;
                            cur_stage <= '0;
                            // A halt seen anywhere in this instruction stops at its boundary.
                            if (halt || halt_seen) begin
                                state    <= S_IDLE;
                                stage_en <= '0;
                                busy     <= 1'b0;
                            end else begin
                                stage_en <= stage_onehot('0);
                            end
                        end
                    end
`ifdef CANDY_STAGE_WDT_EN
                    else if (wait_cnt == WDT_W'(TIMEOUT - 1)) begin
                        state    <= S_ERR;
                        stage_en <= '0;
                        busy     <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_ERR: begin
                    stage_en <= '0;
                    busy     <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_candy_stage_ctrl.sv
// Directed bench for candy_stage_ctrl: flow, stall, skip, halt, reset, watchdog and counter wrap.
module tb_candy_stage_ctrl;

    localparam int N  = 4;
    localparam int CW = 4;
`ifdef CANDY_STAGE_WDT_EN
    localparam bit WDT = 1'b1;
`else
    localparam bit WDT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          halt;
    logic [N-1:0]  stage_done;
    logic [N-1:0]  stage_skip;
    logic [N-1:0]  stage_en;
    logic [1:0]    cur_stage;
    logic          pc_enable;
    logic          busy;
    logic [CW-1:0] retired;
    logic          err;

    int checks = 0;
    int errors = 0;

    candy_stage_ctrl #(
        .NUM_STAGES(N),
        .CNT_W     (CW),
        .TIMEOUT   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .halt      (halt),
        .stage_done(stage_done),
        .stage_skip(stage_skip),
        .stage_en  (stage_en),
        .cur_stage (cur_stage),
        .pc_enable (pc_enable),
        .busy      (busy),
        .retired   (retired),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".en"},   32'(stage_en), 32'h0);
        chk({tag, ".cur"},  32'(cur_stage), 32'h0);
        chk({tag, ".pc"},   32'(pc_enable), 32'h0);
        chk({tag, ".busy"}, 32'(busy), 32'h0);
        chk({tag, ".ret"},  32'(retired), 32'h0);
        chk({tag, ".err"},  32'(err), 32'h0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; halt = 1'b0;
        stage_done = '0; stage_skip = '0;
        tick(); tick();
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Flow: every stage completes immediately.
        stage_done = 4'hF;
        run = 1'b1;
        tick();
        run = 1'b0;
        for (int i = 0; i <= 12; i++) begin
            chk($sformatf("flow.en%0d", i),  32'(stage_en), 32'(1 << (i % 4)));
            chk($sformatf("flow.pc%0d", i),  32'(pc_enable), 32'((i % 4 == 0) && (i > 0)));
            chk($sformatf("flow.ret%0d", i), 32'(retired), 32'(i / 4));
            chk($sformatf("flow.busy%0d", i), 32'(busy), 32'h1);
            if (i < 12) tick();
        end

        // Stall: stage 1 done withheld for 5 edges.
        stage_done = 4'b1101;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("stall.en%0d", c),  32'(stage_en), 32'h2);
            chk($sformatf("stall.ret%0d", c), 32'(retired), 32'h3);
        end
        stage_done = 4'hF;
        tick();
        chk("stall.adv", 32'(stage_en), 32'h4);
        tick();
        chk("stall.en8", 32'(stage_en), 32'h8);
        tick();
        chk("stall.wrap_en", 32'(stage_en), 32'h1);
        chk("stall.pc", 32'(pc_enable), 32'h1);
        chk("stall.ret", 32'(retired), 32'h4);

        // Skip stages 1 and 2.
        stage_skip = 4'b0110;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("skip.en%0d", i),  32'(stage_en), (i % 2) ? 32'h8 : 32'h1);
            chk($sformatf("skip.pc%0d", i),  32'(pc_enable), 32'(i % 2 == 0));
            chk($sformatf("skip.ret%0d", i), 32'(retired), 32'(4 + i / 2));
        end
        stage_skip = '0;

        // Halt pulsed during stage 1 finishes the instruction then idles.
        tick();
        chk("halt.s1", 32'(stage_en), 32'h2);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt.s2", 32'(stage_en), 32'h4);
        tick();
        chk("halt.s3", 32'(stage_en), 32'h8);
        chk("halt.busy3", 32'(busy), 32'h1);
        tick();
        chk("halt.idle_en", 32'(stage_en), 32'h0);
        chk("halt.idle_busy", 32'(busy), 32'h0);
        chk("halt.pc", 32'(pc_enable), 32'h1);
        chk("halt.ret", 32'(retired), 32'h7);
        tick();
        chk("halt.pc_off", 32'(pc_enable), 32'h0);
        run = 1'b1; halt = 1'b1;
        tick();
        chk("runhalt.en", 32'(stage_en), 32'h0);
        chk("runhalt.busy", 32'(busy), 32'h0);
        run = 1'b0; halt = 1'b0;

        // Reset in the middle of stage 2.
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("mid.s0", 32'(stage_en), 32'h1);
        tick(); tick();
        chk("mid.cur", 32'(cur_stage), 32'h2);
        rst = 1'b1;
        tick();
        chk_reset_outputs("midrst");
        rst = 1'b0;

        // Stage 2 never completes: watchdog fires after 8 cycles if built in.
        stage_done = 4'b1011;
        run = 1'b1;
        tick();
        run = 1'b0;
        tick(); tick();
        chk("wdt.entry", 32'(stage_en), 32'h4);
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("wdt.en%0d", c),  32'(stage_en), (WDT && c == 8) ? 32'h0 : 32'h4);
            chk($sformatf("wdt.err%0d", c), 32'(err), 32'(WDT && c == 8));
        end
        run = 1'b1;
        tick(); tick();
        run = 1'b0;
        chk("wdt.sticky_err", 32'(err), 32'(WDT));
        chk("wdt.sticky_en", 32'(stage_en), WDT ? 32'h0 : 32'h4);
        chk("wdt.sticky_busy", 32'(busy), WDT ? 32'h0 : 32'h1);
        rst = 1'b1;
        tick();
        chk_reset_outputs("wdtrst");
        rst = 1'b0;

        // Single-stage instructions wrap the 4-bit counter.
        stage_done = 4'hF;
        stage_skip = 4'hF;
        run = 1'b1;
        tick();
        run = 1'b0;
        chk("wrap.start", 32'(retired), 32'h0);
        for (int k = 1; k <= 17; k++) begin
            tick();
            chk($sformatf("wrap.ret%0d", k), 32'(retired), 32'(k % 16));
            chk($sformatf("wrap.en%0d", k),  32'(stage_en), 32'h1);
            chk($sformatf("wrap.pc%0d", k),  32'(pc_enable), 32'h1);
        end
        chk("wrap.final", 32'(retired), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
